// File: rtl/traffic_display_driver.sv
// Multiplexed 4-digit countdown display driver with per-frame snapshotting
// and registered traffic lamp outputs.
module traffic_display_driver #(
  parameter int SCAN_DIV = 4,
  parameter bit LZB      = 1'b1
) (
  input  logic       CLK,
  input  logic       R,
  input  logic [3:0] A_Time_H,
  input  logic [3:0] A_Time_L,
  input  logic [3:0] B_Time_H,
  input  logic [3:0] B_Time_L,
  input  logic       A_Light,
  input  logic       B_Light,
  output logic [6:0] SEG,
  output logic [3:0] DIG,
  output logic       A_Green,
  output logic       A_Red,
  output logic       B_Green,
  output logic       B_Red,
  output logic       FRAME
);

  localparam logic [15:0] LAST_CNT = 16'(SCAN_DIV - 1);

  logic [15:0] div_cnt;
  logic [1:0]  idx;
  logic [3:0]  snap [4];
  logic        slot_end;
  logic        frame_end;
  logic [3:0]  cur_digit;
  logic [6:0]  seg_next;
  logic [3:0]  dig_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hF: s = 7'h00;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign slot_end  = (div_cnt == LAST_CNT);
  assign frame_end = slot_end && (idx == 2'd3);
  assign cur_digit = snap[idx];

  always_ff @(posedge CLK) begin
    if (R) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Digits are latched once per frame so a frame never mixes old and new values.
  always_ff @(posedge CLK) begin
    if (R) begin
      for (int i = 0; i < 4; i++) snap[i] <= 4'hF;
      FRAME <= 1'b0;
    end else begin
      if (frame_end) begin
        snap[0] <= A_Time_H;
        snap[1] <= A_Time_L;
        snap[2] <= B_Time_H;
        snap[3] <= B_Time_L;
      end
      FRAME <= frame_end;
    end
  end

  // Even slots hold the high digits, which are the only ones zero-blanked.
  always_comb begin
    seg_next = decode(cur_digit);
    dig_next = 4'b0001 << idx;
    if (LZB && !idx[0] && (cur_digit == 4'h0)) seg_next = 7'h00;
    if (div_cnt == 16'd0) begin
      seg_next = 7'h00;
      dig_next = 4'b0000;
    end
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      SEG <= 7'h00;
      DIG <= 4'b0000;
    end else begin
      SEG <= seg_next;
      DIG <= dig_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      A_Green <= 1'b0;
      A_Red   <= 1'b1;
      B_Green <= 1'b0;
      B_Red   <= 1'b1;
    end else begin
      A_Green <= A_Light;
      A_Red   <= ~A_Light;
      B_Green <= B_Light;
      B_Red   <= ~B_Light;
    end
  end

endmodule

// File: tb/tb_traffic_display_driver.sv
// Self-checking bench: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_traffic_display_driver;

  localparam int SD = 4;
  localparam int FL = 4 * SD;

  logic       CLK;
  logic       R;
  logic [3:0] A_Time_H, A_Time_L, B_Time_H, B_Time_L;
  logic       A_Light, B_Light;
  logic [6:0] SEG;
  logic [3:0] DIG;
  logic       A_Green, A_Red, B_Green, B_Red, FRAME;

  int errors = 0;
  int checks = 0;
  int ek;

  traffic_display_driver #(.SCAN_DIV(SD), .LZB(1'b1)) dut (
    .CLK(CLK), .R(R),
    .A_Time_H(A_Time_H), .A_Time_L(A_Time_L),
    .B_Time_H(B_Time_H), .B_Time_L(B_Time_L),
    .A_Light(A_Light), .B_Light(B_Light),
    .SEG(SEG), .DIG(DIG),
    .A_Green(A_Green), .A_Red(A_Red), .B_Green(B_Green), .B_Red(B_Red),
    .FRAME(FRAME)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: position within the frame is derived from the edge count since reset.
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h00};
  logic [3:0] m_snap [4];
  logic [6:0] m_seg;
  logic [3:0] m_dig;
  logic       m_frame, m_ag, m_ar, m_bg, m_br;
  logic       m_valid = 1'b0;
  int         m_k = 0;

  always @(posedge CLK) begin
    int pos, slot, digit;
    if (R) begin
      m_seg <= 7'h00; m_dig <= 4'h0; m_frame <= 1'b0;
      m_ag <= 1'b0; m_ar <= 1'b1; m_bg <= 1'b0; m_br <= 1'b1;
      for (int i = 0; i < 4; i++) m_snap[i] <= 4'hF;
      m_k <= 0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      pos   = m_k % FL;
      slot  = pos / SD;
      digit = int'(m_snap[slot]);
      if (pos % SD == 0) begin
        m_seg <= 7'h00;
        m_dig <= 4'h0;
      end else begin
        m_dig <= 4'(1 << slot);
        m_seg <= (slot % 2 == 0 && digit == 0) ? 7'h00 : seg_tab[digit];
      end
      m_frame <= (pos == FL - 1);
      if (pos == FL - 1) begin
        m_snap[0] <= A_Time_H; m_snap[1] <= A_Time_L;
        m_snap[2] <= B_Time_H; m_snap[3] <= B_Time_L;
      end
      m_ag <= A_Light; m_ar <= ~A_Light;
      m_bg <= B_Light; m_br <= ~B_Light;
      m_k <= m_k + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (m_valid) begin
      checkOutput("model_seg", 32'(SEG), 32'(m_seg));
      checkOutput("model_dig", 32'(DIG), 32'(m_dig));
      checkOutput("model_frame", 32'(FRAME), 32'(m_frame));
      checkOutput("model_lamps", 32'({A_Green, A_Red, B_Green, B_Red}),
                  32'({m_ag, m_ar, m_bg, m_br}));
      checkOutput("lamp_overlap", 32'((A_Green & A_Red) | (B_Green & B_Red)), 32'd0);
    end
  end

  task automatic applyStimulus(input logic [3:0] ah, input logic [3:0] al,
                               input logic [3:0] bh, input logic [3:0] bl,
                               input logic la, input logic lb);
    A_Time_H = ah; A_Time_L = al; B_Time_H = bh; B_Time_L = bl;
    A_Light = la; B_Light = lb;
  endtask

  task automatic step();
    @(negedge CLK);
    ek++;
  endtask

  task automatic stepTo(input int target);
    while (ek < target) step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [6:0] exp_seg [4] = '{7'h7F, 7'h6F, 7'h7F, 7'h6F};
    logic a;
    R = 1'b1;
    applyStimulus(4'h8, 4'h9, 4'h8, 4'h9, 1'b1, 1'b1);
    ek = 0;
    step(); step();
    checkOutput("rst_seg", 32'(SEG), 32'h00);
    checkOutput("rst_dig", 32'(DIG), 32'h0);
    checkOutput("rst_lamps", 32'({A_Green, A_Red, B_Green, B_Red}), 32'b0101);
    checkOutput("rst_frame", 32'(FRAME), 32'h0);

    R = 1'b0;
    ek = -1;
    stepTo(1);
    checkOutput("blank_first_frame_seg", 32'(SEG), 32'h00);
    checkOutput("blank_first_frame_dig", 32'(DIG), 32'b0001);
    stepTo(14);
    checkOutput("frame_low", 32'(FRAME), 32'h0);
    step();
    checkOutput("frame_pulse1", 32'(FRAME), 32'h1);
    for (int k = 16; k < 32; k++) begin
      step();
      if ((k - 16) % SD == 0) begin
        checkOutput("dead_dig", 32'(DIG), 32'h0);
        checkOutput("dead_seg", 32'(SEG), 32'h00);
      end else begin
        checkOutput("frame1_dig", 32'(DIG), 32'(1 << ((k - 16) / SD)));
        checkOutput("frame1_seg", 32'(SEG), 32'(exp_seg[(k - 16) / SD]));
      end
    end

    stepTo(37);
    A_Time_L = 4'h5;
    stepTo(39);
    checkOutput("tear_hold_seg", 32'(SEG), 32'h6F);
    checkOutput("tear_hold_dig", 32'(DIG), 32'b0010);
    stepTo(47);
    checkOutput("frame_pulse3", 32'(FRAME), 32'h1);
    stepTo(53);
    checkOutput("tear_new_seg", 32'(SEG), 32'h6D);

    applyStimulus(4'h0, 4'hC, 4'hF, 4'hF, A_Light, B_Light);
    stepTo(65);
    checkOutput("lzb_seg", 32'(SEG), 32'h00);
    checkOutput("lzb_dig", 32'(DIG), 32'b0001);
    stepTo(69);
    checkOutput("invalid_seg", 32'(SEG), 32'h40);
    stepTo(73);
    checkOutput("blank_bh_seg", 32'(SEG), 32'h00);
    checkOutput("blank_bh_dig", 32'(DIG), 32'b0100);
    stepTo(77);
    checkOutput("blank_bl_seg", 32'(SEG), 32'h00);

    for (int i = 0; i < 8; i++) begin
      a = 1'(i % 2);
      A_Light = a;
      B_Light = ~a;
      step();
      checkOutput("blink_a", 32'({A_Green, A_Red}), 32'({a, ~a}));
      checkOutput("blink_b", 32'({B_Green, B_Red}), 32'({~a, a}));
    end

    stepTo(90);
    applyStimulus(4'h1, 4'h2, 4'h3, 4'h4, A_Light, B_Light);
    stepTo(94);
    R = 1'b1;
    step();
    checkOutput("midrst_frame", 32'(FRAME), 32'h0);
    checkOutput("midrst_seg", 32'(SEG), 32'h00);
    checkOutput("midrst_dig", 32'(DIG), 32'h0);
    checkOutput("midrst_lamps", 32'({A_Green, A_Red, B_Green, B_Red}), 32'b0101);
    R = 1'b0;
    ek = -1;
    stepTo(1);
    checkOutput("midrst_blank_ah", 32'(SEG), 32'h00);
    checkOutput("midrst_dig_ah", 32'(DIG), 32'b0001);
    stepTo(5);
    checkOutput("midrst_blank_al", 32'(SEG), 32'h00);
    stepTo(15);
    checkOutput("midrst_frame_pulse", 32'(FRAME), 32'h1);
    stepTo(17);
    checkOutput("midrst_loaded_ah", 32'(SEG), 32'h06);
    stepTo(21);
    checkOutput("midrst_loaded_al", 32'(SEG), 32'h5B);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_display_driver.md
TRAFFIC_DISPLAY_DRIVER -- requirements
Module: traffic_display_driver

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles per digit slot; legal range 2..65535.
REQ-002 Parameter LZB, default 1: 1 blanks a high digit whose value is 0 (leading-zero blanking).
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 R  in  1  reset, synchronous, active-high.
REQ-005 A_Time_H, A_Time_L, B_Time_H, B_Time_L  in  4 each  BCD countdown digits from the controller; 4'hF means blank.
REQ-006 A_Light, B_Light  in  1 each  controller green request per approach.
REQ-007 SEG  out  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
REQ-008 DIG  out  4  one-hot digit enable, active-high; bit0=A_Time_H, bit1=A_Time_L, bit2=B_Time_H, bit3=B_Time_L.
REQ-009 A_Green, A_Red, B_Green, B_Red  out  1 each  lamp drives, active-high.
REQ-010 FRAME  out  1  one-cycle pulse on every snapshot load.

Function
REQ-011 Slot counter div_cnt counts 0..SCAN_DIV-1 and wraps to 0; it is 16 bits wide.
REQ-012 Digit index idx is 2 bits; it increments when div_cnt==SCAN_DIV-1 and wraps from 3 to 0.
REQ-013 Snapshot registers hold all four digits; they load from the inputs when div_cnt==SCAN_DIV-1 and idx==3 (end of frame).
REQ-014 FRAME is 1 in the cycle after a snapshot load and 0 in all other cycles.
REQ-015 Input digit changes inside a frame do not affect the display until the next snapshot load, so a frame never shows mixed values.
REQ-016 SEG and DIG are registered with 1-cycle latency from the (div_cnt, idx, snapshot) values of the previous cycle.
REQ-017 Dead time: DIG is 4'b0000 and SEG is 7'h00 for the slot cycle in which div_cnt==0.
REQ-018 For div_cnt!=0, DIG is one-hot(idx) and SEG is the decode of the snapshot digit selected by idx.
REQ-019 Decode table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A..E=40 (dash, invalid code), F=00 (blank).
REQ-020 When LZB=1 and a snapshot H digit is 0, its SEG is 00; DIG still asserts for that slot. L digits are never zero-blanked.
REQ-021 Lamps are registered with 1-cycle latency: A_Green<=A_Light, A_Red<=~A_Light, B_Green<=B_Light, B_Red<=~B_Light.
REQ-022 Lamps are not frame-synchronised; they follow inputs every cycle, so toggling (blink) inputs pass through.
REQ-023 A green output and the red output of the same approach are never both 1 in the same cycle.
REQ-024 Full frame length is 4*SCAN_DIV cycles; the first frame after reset displays the reset snapshot (blank).

Reset
REQ-025 R=1 at an edge sets div_cnt=0, idx=0, all snapshots=4'hF, SEG=00, DIG=0000, FRAME=0.
REQ-026 During reset the lamps are A_Red=1, B_Red=1, A_Green=0, B_Green=0 (all-red), regardless of A_Light and B_Light.
REQ-027 Reset asserted mid-frame aborts the frame immediately and does not load the snapshot in that cycle.
REQ-028 After R falls, counting starts at div_cnt=0, idx=0 on the first non-reset edge.

Verification
REQ-029 Reset check, SCAN_DIV=4: R=1 for 2 cycles -> SEG=00, DIG=0000, A_Red=B_Red=1, A_Green=B_Green=0, FRAME=0.
REQ-030 Normal display: inputs 8,9,8,9; release reset; wait 1 frame (16 cycles) -> FRAME pulses; next frame shows DIG 0001/SEG 7F, 0010/6F, 0100/7F, 1000/6F, each for 3 cycles, separated by one 0000 dead cycle.
REQ-031 Tearing check: change A_Time_L from 9 to 5 at idx=1, div_cnt=2 -> that frame keeps showing 6F; SEG 6D appears only after the next FRAME pulse.
REQ-032 Blank, invalid and LZB check, LZB=1: A_Time_H=0, A_Time_L=C, B digits=F,F -> slots show 00, 40, 00, 00.
REQ-033 Lamp blink check: toggle A_Light and B_Light in antiphase every cycle -> A_Green/A_Red and B_Green/B_Red follow one cycle later, never overlapping per approach.
REQ-034 Mid-operation reset: assert R at idx=3, div_cnt=3 with new inputs present -> no FRAME pulse, snapshots=F, and the next frame is blank.
